boot_loader: RTL

Synthesizable program loader. It holds the 6502 core in reset, accepts a framed byte stream, and writes it into the shared program RAM. On a valid RUN record it supplies the reset vector and releases the core. It replaces testbench-only preloading and sits between the host byte source (UART/debug port) and the RAM write port, muxed with the CPU port by cpu_rst.
- Generalised over the hand-written loader: parametrised address width, block-write and fill modes, per-record checksum, and error/restart handling.

---
 rtl/boot_loader_defs.sv | 24 ++
 rtl/boot_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/boot_loader_defs.sv
// Shared definitions for the program loader: record command codes and FSM states.
package boot_loader_defs;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_FILL  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  typedef enum logic [3:0] {
    S_CMD,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_FVAL,
    S_FILL,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  function automatic logic state_accepts(input state_t s);
    return s inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_FVAL, S_CSUM};
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Framed-record program loader: writes the 6502 program RAM while holding the
// core in reset, then releases it with the reset vector from a RUN record.
module boot_loader
  import boot_loader_defs::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_en,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] pc_reset,
  output logic              done,
  output logic              err
);

  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned IDX_W      = $clog2(ADDR_BYTES + 1);
  localparam int unsigned CNT_W      = LEN_W + 1;

  if (DATA_W != 8) begin : g_bad_data_w
    $error("boot_loader: DATA_W must be 8");
  end
  if (LEN_W < 1 || LEN_W > 8) begin : g_bad_len_w
    $error("boot_loader: LEN_W must be 1..8");
  end

  state_t              state;
  logic                live;
  logic [7:0]          cmd;
  logic [7:0]          sum;
  logic [DATA_W-1:0]   fill_val;
  logic [ADDR_W-1:0]   addr;
  logic [IDX_W-1:0]    abytes_left;
  logic [CNT_W-1:0]    len;
  logic                take;
  logic [LEN_W-1:0]    len_field;

  // live keeps in_ready low throughout reset even though state resets to S_CMD
  assign in_ready  = live & state_accepts(state);
  assign take      = in_valid & in_ready;
  assign len_field = in_data[LEN_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_CMD;
      live         <= 1'b0;
      cmd          <= '0;
      sum          <= '0;
      fill_val     <= '0;
      addr         <= '0;
      abytes_left  <= '0;
      len          <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      cpu_rst      <= 1'b0;
      pc_reset     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      live         <= 1'b1;
      mem_write_en <= 1'b0;
      if (restart) begin
        state   <= S_CMD;
        err     <= 1'b0;
        done    <= 1'b0;
        cpu_rst <= 1'b0;
      end else begin
        case (state)
          S_CMD: if (take) begin
            cmd <= in_data;
            sum <= in_data;
            if (in_data inside {CMD_WRITE, CMD_FILL, CMD_RUN}) begin
              state       <= S_ADDR;
              abytes_left <= IDX_W'(ADDR_BYTES - 1);
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          S_ADDR: if (take) begin
            sum  <= 8'(sum + in_data);
            // shifting big-endian bytes through an ADDR_W register truncates to the low bits
            addr <= ADDR_W'({addr, in_data});
            if (abytes_left == '0) state <= S_LEN;
            else abytes_left <= abytes_left - IDX_W'(1);
          end
          S_LEN: if (take) begin
            sum <= 8'(sum + in_data);
            len <= (len_field == '0) ? (CNT_W'(1) << LEN_W) : CNT_W'(len_field);
            if (cmd == CMD_WRITE) state <= S_DATA;
            else if (cmd == CMD_FILL) state <= S_FVAL;
            else if (in_data != 8'h00) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else state <= S_CSUM;
          end
          S_DATA: if (take) begin
            sum          <= 8'(sum + in_data);
            mem_write_en <= 1'b1;
            mem_addr     <= addr;
            mem_data     <= in_data;
            addr         <= addr + ADDR_W'(1);
            len          <= len - CNT_W'(1);
            if (len == CNT_W'(1)) state <= S_CSUM;
          end
          S_FVAL: if (take) begin
            sum      <= 8'(sum + in_data);
            fill_val <= in_data;
            state    <= S_FILL;
          end
          S_FILL: begin
            mem_write_en <= 1'b1;
            mem_addr     <= addr;
            mem_data     <= fill_val;
            addr         <= addr + ADDR_W'(1);
            len          <= len - CNT_W'(1);
            if (len == CNT_W'(1)) state <= S_CSUM;
          end
          S_CSUM: if (take) begin
            if (8'(sum + in_data) == 8'h00) begin
              if (cmd == CMD_RUN) begin
                state    <= S_RUN;
                pc_reset <= addr;
                cpu_rst  <= 1'b1;
                done     <= 1'b1;
              end else state <= S_CMD;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          S_RUN, S_ERR: ;
          default: state <= S_CMD;
        endcase
      end
    end
  end

endmodule
